// File: rtl/stream_width_gearbox_pkg.sv
// Shared types and elaboration helpers
// for the stream width gearbox.
package gearbox_pkg;

  typedef enum logic [1:0] {
    GB_PASS,
    GB_PACK,
    GB_UNPACK
  } gb_mode_e;

  function automatic gb_mode_e gb_mode(
    input int in_w,
    input int out_w
  );
    if (in_w < out_w) return GB_PACK;
    if (in_w > out_w) return GB_UNPACK;
    return GB_PASS;
  endfunction

  function automatic int gb_ratio(
    input int in_w,
    input int out_w
  );
    int mx;
    int mn;
    mx = (in_w > out_w) ? in_w : out_w;
    mn = (in_w > out_w) ? out_w : in_w;
    if (mn < 1) mn = 1;
    return mx / mn;
  endfunction

  // Physical lane of the idx-th narrow beat.
  function automatic int lane_pos(
    input int idx,
    input int r,
    input bit lsb_first
  );
    return lsb_first ? idx : (r - 1 - idx);
  endfunction

endpackage

// File: rtl/stream_width_gearbox_if.sv
// Valid/ready stream bundle with
// per-lane keep and packet last.
interface stream_width_gearbox_if #(
  parameter int W = 8,
  parameter int K = 1
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic [K-1:0] keep;
  logic         last;

  modport master (
    output valid,
    output data,
    output keep,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  keep,
    input  last,
    output ready
  );

endinterface

// File: rtl/stream_width_gearbox_xz_mon.sv
// Sticky X/Z flag and saturating
// count of accepted dirty beats.
module gearbox_xz_mon
  import gearbox_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fire,
  input  logic [W-1:0] data,
  output logic         err,
  output logic [7:0]   cnt
);

  logic       dirty;
  logic       err_d;
  logic       err_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_q;

  assign dirty = fire && $isunknown(data);

  // Flag sticks, count stops at 255
  always_comb begin
    err_d = err_q || dirty;
    cnt_d = cnt_q;
    if (dirty && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  // Monitor state, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err = err_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/stream_width_gearbox.sv
// Valid/ready width converter: lane
// packing, unpacking or pass-through.
module stream_width_gearbox
  import gearbox_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  stream_width_gearbox_if.slave  in_s,
  stream_width_gearbox_if.master out_s,
  output logic       xz_err,
  output logic [7:0] xz_cnt
);

  localparam gb_mode_e MODE = gb_mode(IN_W, OUT_W);
  localparam int R      = gb_ratio(IN_W, OUT_W);
  localparam int KEEP_W = R;
  localparam int NW     = (IN_W < OUT_W) ? IN_W : OUT_W;
  localparam int MXW    = (IN_W < OUT_W) ? OUT_W : IN_W;
  localparam int MNW    = (NW < 1) ? 1 : NW;
  localparam int IDX_W  = (R > 1) ? $clog2(R) : 1;
  localparam int CW     = $clog2(R + 1);

  if (IN_W < 1 || OUT_W < 1 || (MXW % MNW) != 0) begin : g_bad
    $fatal(1, "stream_width_gearbox: widths not integer ratio");
  end

  logic in_ready_w;
  logic in_fire;

  assign in_s.ready = in_ready_w;
  assign in_fire    = in_s.valid && in_ready_w && !rst;

  gearbox_xz_mon #(
    .W (IN_W)
  ) u_xz_mon (
    .clk  (clk),
    .rst  (rst),
    .fire (in_fire),
    .data (in_s.data),
    .err  (xz_err),
    .cnt  (xz_cnt)
  );

  if (MODE == GB_PASS) begin : g_pass

    logic [OUT_W-1:0]  data_d, data_q;
    logic [KEEP_W-1:0] keep_d, keep_q;
    logic              valid_d, valid_q;
    logic              last_d, last_q;
    logic              unused_keep;

    assign unused_keep = ^in_s.keep;
    assign in_ready_w  = rst || !valid_q || out_s.ready;

    // Refill the output register when empty or draining
    always_comb begin
      valid_d = valid_q && !out_s.ready;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (in_fire) begin
        valid_d = 1'b1;
        data_d  = in_s.data;
        keep_d  = '1;
        last_d  = in_s.last;
      end
    end

    // Output register
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
      end
    end

    assign out_s.valid = valid_q;
    assign out_s.data  = data_q;
    assign out_s.keep  = keep_q;
    assign out_s.last  = last_q;

  end else if (MODE == GB_PACK) begin : g_pack

    logic [OUT_W-1:0]  acc_d, acc_q, word;
    logic [KEEP_W-1:0] akeep_d, akeep_q, wkeep;
    logic [IDX_W-1:0]  idx_d, idx_q;
    logic [OUT_W-1:0]  data_d, data_q;
    logic [KEEP_W-1:0] keep_d, keep_q;
    logic              valid_d, valid_q;
    logic              last_d, last_q;
    logic              at_end;
    logic              unused_keep;

    assign unused_keep = ^in_s.keep;
    assign at_end = (idx_q == IDX_W'(R - 1)) || in_s.last;
    // Non-completing beats only touch the accumulator
    assign in_ready_w = rst || !valid_q || out_s.ready || !at_end;

    // Merge the beat into its lane; flush on last lane or in_last
    always_comb begin
      word  = acc_q;
      wkeep = akeep_q;
      word[lane_pos(int'(idx_q), R, LSB_FIRST) * NW +: NW] = in_s.data;
      wkeep[lane_pos(int'(idx_q), R, LSB_FIRST)] = 1'b1;
      acc_d   = acc_q;
      akeep_d = akeep_q;
      idx_d   = idx_q;
      valid_d = valid_q && !out_s.ready;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (in_fire) begin
        if (at_end) begin
          valid_d = 1'b1;
          data_d  = word;
          keep_d  = wkeep;
          last_d  = in_s.last;
          acc_d   = '0;
          akeep_d = '0;
          idx_d   = '0;
        end else begin
          acc_d   = word;
          akeep_d = wkeep;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
    end

    // Accumulator and output register
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q   <= '0;
        akeep_q <= '0;
        idx_q   <= '0;
        valid_q <= 1'b0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        acc_q   <= acc_d;
        akeep_q <= akeep_d;
        idx_q   <= idx_d;
        valid_q <= valid_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
      end
    end

    assign out_s.valid = valid_q;
    assign out_s.data  = data_q;
    assign out_s.keep  = keep_q;
    assign out_s.last  = last_q;

  end else begin : g_unpack

    logic [IN_W-1:0]   word_d, word_q;
    logic [IDX_W-1:0]  cur_d, cur_q;
    logic [IDX_W-1:0]  end_d, end_q;
    logic              wlast_d, wlast_q;
    logic [OUT_W-1:0]  data_d, data_q;
    logic [KEEP_W-1:0] keep_d, keep_q;
    logic              valid_d, valid_q;
    logic              last_d, last_q;
    logic [CW-1:0]     n_lanes;
    logic [IDX_W-1:0]  in_end;
    logic              last_lane;

    assign n_lanes = CW'($countones(in_s.keep));
    // Empty keep still carries one lane
    assign in_end = (n_lanes == '0) ? '0
                  : IDX_W'(n_lanes - CW'(1));
    assign last_lane = (cur_q == end_q);
    // Next word may enter as the final lane leaves
    assign in_ready_w = rst || !valid_q
                     || (out_s.ready && last_lane);

    // Load a word with lane 0 out, then step lanes on each drain
    always_comb begin
      word_d  = word_q;
      cur_d   = cur_q;
      end_d   = end_q;
      wlast_d = wlast_q;
      valid_d = valid_q && !out_s.ready;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      if (in_fire) begin
        word_d  = in_s.data;
        cur_d   = '0;
        end_d   = in_end;
        wlast_d = in_s.last;
        valid_d = 1'b1;
        data_d  = in_s.data[lane_pos(0, R, LSB_FIRST) * NW +: NW];
        keep_d  = '1;
        last_d  = in_s.last && (in_end == '0);
      end else if (valid_q && out_s.ready && !last_lane) begin
        cur_d   = cur_q + IDX_W'(1);
        valid_d = 1'b1;
        data_d  = word_q[lane_pos(int'(cur_d), R, LSB_FIRST) * NW +: NW];
        last_d  = wlast_q && (cur_d == end_q);
      end
    end

    // Word holding register and output lane register
    always_ff @(posedge clk) begin
      if (rst) begin
        word_q  <= '0;
        cur_q   <= '0;
        end_q   <= '0;
        wlast_q <= 1'b0;
        valid_q <= 1'b0;
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        word_q  <= word_d;
        cur_q   <= cur_d;
        end_q   <= end_d;
        wlast_q <= wlast_d;
        valid_q <= valid_d;
        data_q  <= data_d;
        keep_q  <= keep_d;
        last_q  <= last_d;
      end
    end

    assign out_s.valid = valid_q;
    assign out_s.data  = data_q;
    assign out_s.keep  = keep_q;
    assign out_s.last  = last_q;

  end

endmodule

// File: tb/tb_stream_width_gearbox.sv
// Directed bench for the gearbox in
// pack (both orders), unpack and pass.
module tb_stream_width_gearbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmps = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  stream_width_gearbox_if #(.W(8),  .K(4)) p_in ();
  stream_width_gearbox_if #(.W(32), .K(4)) p_out ();
  stream_width_gearbox_if #(.W(8),  .K(4)) m_in ();
  stream_width_gearbox_if #(.W(32), .K(4)) m_out ();
  stream_width_gearbox_if #(.W(32), .K(4)) u_in ();
  stream_width_gearbox_if #(.W(8),  .K(4)) u_out ();
  stream_width_gearbox_if #(.W(8),  .K(1)) s_in ();
  stream_width_gearbox_if #(.W(8),  .K(1)) s_out ();

  logic       p_err, m_err, u_err, s_err;
  logic [7:0] p_cnt, m_cnt, u_cnt, s_cnt;

  stream_width_gearbox #(.IN_W(8), .OUT_W(32), .LSB_FIRST(1'b1)) u_pack (
    .clk(clk), .rst(rst), .in_s(p_in), .out_s(p_out),
    .xz_err(p_err), .xz_cnt(p_cnt));

  stream_width_gearbox #(.IN_W(8), .OUT_W(32), .LSB_FIRST(1'b0)) u_packm (
    .clk(clk), .rst(rst), .in_s(m_in), .out_s(m_out),
    .xz_err(m_err), .xz_cnt(m_cnt));

  stream_width_gearbox #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1'b1)) u_unpack (
    .clk(clk), .rst(rst), .in_s(u_in), .out_s(u_out),
    .xz_err(u_err), .xz_cnt(u_cnt));

  stream_width_gearbox #(.IN_W(8), .OUT_W(8), .LSB_FIRST(1'b1)) u_pass (
    .clk(clk), .rst(rst), .in_s(s_in), .out_s(s_out),
    .xz_err(s_err), .xz_cnt(s_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pk_send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    p_in.valid = 1'b1; p_in.data = d; p_in.last = l;
    m_in.valid = 1'b1; m_in.data = d; m_in.last = l;
    #1;
    while (!(p_in.ready && m_in.ready) && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      cmps++; errs++;
      $display("FAIL pk_send_timeout data=%h", d);
    end
    tick();
    p_in.valid = 1'b0; p_in.last = 1'b0;
    m_in.valid = 1'b0; m_in.last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    cmps++; if (p_out.valid !== 1'b0) begin errs++; $display("FAIL rst_p_valid got %b want 0", p_out.valid); end
    cmps++; if (p_out.data !== 32'h0) begin errs++; $display("FAIL rst_p_data got %h want 0", p_out.data); end
    cmps++; if (p_out.keep !== 4'h0) begin errs++; $display("FAIL rst_p_keep got %b want 0000", p_out.keep); end
    cmps++; if (p_out.last !== 1'b0) begin errs++; $display("FAIL rst_p_last got %b want 0", p_out.last); end
    cmps++; if (p_in.ready !== 1'b1) begin errs++; $display("FAIL rst_p_ready got %b want 1", p_in.ready); end
    cmps++; if (p_err !== 1'b0 || p_cnt !== 8'd0) begin errs++; $display("FAIL rst_p_xz got %b/%0d want 0/0", p_err, p_cnt); end
    cmps++; if (u_out.valid !== 1'b0 || u_out.data !== 8'h0) begin errs++; $display("FAIL rst_u_out got %b/%h want 0/00", u_out.valid, u_out.data); end
    cmps++; if (u_in.ready !== 1'b1) begin errs++; $display("FAIL rst_u_ready got %b want 1", u_in.ready); end
    cmps++; if (s_out.valid !== 1'b0 || s_in.ready !== 1'b1) begin errs++; $display("FAIL rst_s got v=%b r=%b want 0/1", s_out.valid, s_in.ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pack_full();
    pk_send(8'h11, 1'b0);
    pk_send(8'h22, 1'b0);
    pk_send(8'h33, 1'b0);
    cmps++; if (p_out.valid !== 1'b0) begin errs++; $display("FAIL pack_early got %b want 0", p_out.valid); end
    pk_send(8'h44, 1'b0);
    cmps++; if (p_out.valid !== 1'b1) begin errs++; $display("FAIL pack_valid got %b want 1", p_out.valid); end
    cmps++; if (p_out.data !== 32'h44332211) begin errs++; $display("FAIL pack_data got %h want 44332211", p_out.data); end
    cmps++; if (p_out.keep !== 4'b1111 || p_out.last !== 1'b0) begin errs++; $display("FAIL pack_keep got %b/%b want 1111/0", p_out.keep, p_out.last); end
    cmps++; if (m_out.data !== 32'h11223344) begin errs++; $display("FAIL packm_data got %h want 11223344", m_out.data); end
    tick();
    cmps++; if (p_out.valid !== 1'b0) begin errs++; $display("FAIL pack_drained got %b want 0", p_out.valid); end
  endtask

  task automatic test_pack_last();
    pk_send(8'hAA, 1'b0);
    pk_send(8'hBB, 1'b1);
    cmps++; if (p_out.data !== 32'h0000BBAA) begin errs++; $display("FAIL last_data got %h want 0000bbaa", p_out.data); end
    cmps++; if (p_out.keep !== 4'b0011 || p_out.last !== 1'b1) begin errs++; $display("FAIL last_keep got %b/%b want 0011/1", p_out.keep, p_out.last); end
    cmps++; if (m_out.data !== 32'hAABB0000) begin errs++; $display("FAIL lastm_data got %h want aabb0000", m_out.data); end
    cmps++; if (m_out.keep !== 4'b1100 || m_out.last !== 1'b1) begin errs++; $display("FAIL lastm_keep got %b/%b want 1100/1", m_out.keep, m_out.last); end
    tick();
    pk_send(8'h5A, 1'b1);
    cmps++; if (p_out.data !== 32'h0000005A || p_out.keep !== 4'b0001) begin errs++; $display("FAIL idx0_last got %h/%b want 0000005a/0001", p_out.data, p_out.keep); end
    cmps++; if (m_out.data !== 32'h5A000000 || m_out.keep !== 4'b1000) begin errs++; $display("FAIL idx0_lastm got %h/%b want 5a000000/1000", m_out.data, m_out.keep); end
    tick();
  endtask

  task automatic test_pack_drain();
    p_out.ready = 1'b0;
    m_out.ready = 1'b0;
    pk_send(8'h01, 1'b0);
    pk_send(8'h02, 1'b0);
    pk_send(8'h03, 1'b0);
    pk_send(8'h04, 1'b0);
    pk_send(8'h05, 1'b0);
    pk_send(8'h06, 1'b0);
    pk_send(8'h07, 1'b0);
    cmps++; if (p_out.valid !== 1'b1 || p_out.data !== 32'h04030201) begin errs++; $display("FAIL drain_hold got %b/%h want 1/04030201", p_out.valid, p_out.data); end
    p_in.valid = 1'b1; p_in.data = 8'h08;
    m_in.valid = 1'b1; m_in.data = 8'h08;
    #1;
    cmps++; if (p_in.ready !== 1'b0) begin errs++; $display("FAIL drain_stall got %b want 0", p_in.ready); end
    tick();
    cmps++; if (p_out.data !== 32'h04030201) begin errs++; $display("FAIL drain_stable got %h want 04030201", p_out.data); end
    p_out.ready = 1'b1;
    m_out.ready = 1'b1;
    tick();
    p_in.valid = 1'b0;
    m_in.valid = 1'b0;
    cmps++; if (p_out.valid !== 1'b1 || p_out.data !== 32'h08070605) begin errs++; $display("FAIL drain_swap got %b/%h want 1/08070605", p_out.valid, p_out.data); end
    tick();
    cmps++; if (p_out.valid !== 1'b0) begin errs++; $display("FAIL drain_end got %b want 0", p_out.valid); end
  endtask

  task automatic test_unpack();
    logic [7:0] exp_d [7];
    logic       exp_l [7];
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    u_out.ready = 1'b1;
    u_in.valid = 1'b1; u_in.data = 32'hDDCCBBAA;
    u_in.keep = 4'b0111; u_in.last = 1'b1;
    tick();
    u_in.data = 32'h44332211; u_in.keep = 4'b1111; u_in.last = 1'b0;
    cmps++; if (u_in.ready !== 1'b0 || u_out.keep !== 4'b1111) begin errs++; $display("FAIL unp_busy got r=%b k=%b want 0/1111", u_in.ready, u_out.keep); end
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        cmps++; if (u_in.ready !== 1'b1) begin errs++; $display("FAIL unp_nobubble got %b want 1", u_in.ready); end
      end
      cmps++; if (u_out.valid !== 1'b1 || u_out.data !== exp_d[i] || u_out.last !== exp_l[i]) begin
        errs++; $display("FAIL unp_beat%0d got %b/%h/%b want 1/%h/%b", i, u_out.valid, u_out.data, u_out.last, exp_d[i], exp_l[i]);
      end
      tick();
      if (i == 2) u_in.valid = 1'b0;
    end
    cmps++; if (u_out.valid !== 1'b0) begin errs++; $display("FAIL unp_end got %b want 0", u_out.valid); end
    u_in.valid = 1'b1; u_in.data = 32'h000000EE;
    u_in.keep = 4'b0000; u_in.last = 1'b1;
    tick();
    u_in.valid = 1'b0;
    cmps++; if (u_out.data !== 8'hEE || u_out.last !== 1'b1) begin errs++; $display("FAIL unp_keep0 got %h/%b want ee/1", u_out.data, u_out.last); end
    tick();
    cmps++; if (u_out.valid !== 1'b0) begin errs++; $display("FAIL unp_keep0_one got %b want 0", u_out.valid); end
  endtask

  task automatic test_pass_bp();
    logic [7:0] q [$];
    logic [7:0] held;
    logic [7:0] exp;
    logic       stalled;
    logic       fire_in;
    int         sent;
    int         recv;
    int         cyc;
    sent = 0; recv = 0; cyc = 0;
    stalled = 1'b0; held = 8'h0;
    s_in.valid = 1'b1;
    s_in.data = 8'($urandom_range(0, 255));
    s_out.ready = ($urandom_range(0, 9) < 3);
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        cmps++;
        if (s_out.valid !== 1'b1 || s_out.data !== held) begin
          errs++; $display("FAIL bp_stable got %b/%h want 1/%h", s_out.valid, s_out.data, held);
        end
      end
      if (s_out.valid && s_out.ready) begin
        cmps++;
        if (q.size() == 0) begin
          errs++; $display("FAIL bp_extra got %h want none", s_out.data);
        end else begin
          exp = q.pop_front();
          if (s_out.data !== exp) begin errs++; $display("FAIL bp_data%0d got %h want %h", recv, s_out.data, exp); end
        end
        recv++;
      end
      stalled = s_out.valid && !s_out.ready;
      held = s_out.data;
      fire_in = s_in.valid && s_in.ready;
      if (fire_in) begin
        q.push_back(s_in.data);
        sent++;
      end
      tick();
      if (fire_in) begin
        if (sent < 1000) s_in.data = 8'($urandom_range(0, 255));
        else s_in.valid = 1'b0;
      end
      s_out.ready = ($urandom_range(0, 9) < 3);
    end
    s_in.valid = 1'b0;
    s_out.ready = 1'b1;
    cmps++; if (recv != 1000) begin errs++; $display("FAIL bp_count got %0d want 1000", recv); end
    tick();
  endtask

  task automatic test_xz();
    logic [7:0] dirty;
    logic [7:0] v [6];
    logic       exp_err;
    int         exp_cnt;
    dirty = 8'b1x0z_0000;
    v = '{8'h01, dirty, 8'h02, dirty, dirty, 8'h03};
    exp_err = 1'b0;
    exp_cnt = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_out.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_in.valid = 1'b1;
      s_in.data = v[i];
      tick();
      if ($isunknown(v[i])) begin
        exp_err = 1'b1;
        exp_cnt++;
      end
      cmps++; if (s_out.data !== v[i]) begin errs++; $display("FAIL xz_data%0d got %b want %b", i, s_out.data, v[i]); end
      cmps++; if (s_err !== exp_err || s_cnt !== 8'(exp_cnt)) begin errs++; $display("FAIL xz_cnt%0d got %b/%0d want %b/%0d", i, s_err, s_cnt, exp_err, exp_cnt); end
    end
    s_in.data = dirty;
    for (int i = 0; i < 300; i++) begin
      tick();
      if ($isunknown(dirty) && exp_cnt < 255) exp_cnt++;
    end
    s_in.valid = 1'b0;
    tick();
    cmps++; if (s_cnt !== 8'(exp_cnt) || s_err !== exp_err) begin errs++; $display("FAIL xz_sat got %b/%0d want %b/%0d", s_err, s_cnt, exp_err, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    p_out.ready = 1'b1;
    m_out.ready = 1'b1;
    pk_send(8'h11, 1'b0);
    pk_send(8'h22, 1'b0);
    rst = 1'b1;
    tick();
    cmps++; if (p_out.valid !== 1'b0 || p_out.data !== 32'h0 || p_out.keep !== 4'h0 || p_out.last !== 1'b0) begin
      errs++; $display("FAIL mid_rst_out got %b/%h/%b/%b want 0/0/0/0", p_out.valid, p_out.data, p_out.keep, p_out.last);
    end
    cmps++; if (p_in.ready !== 1'b1 || s_err !== 1'b0 || s_cnt !== 8'd0) begin
      errs++; $display("FAIL mid_rst_misc got %b/%b/%0d want 1/0/0", p_in.ready, s_err, s_cnt);
    end
    rst = 1'b0;
    pk_send(8'hA1, 1'b0);
    pk_send(8'hA2, 1'b0);
    pk_send(8'hA3, 1'b0);
    cmps++; if (p_out.valid !== 1'b0) begin errs++; $display("FAIL mid_stale got %b want 0", p_out.valid); end
    pk_send(8'hA4, 1'b0);
    cmps++; if (p_out.valid !== 1'b1 || p_out.data !== 32'hA4A3A2A1 || p_out.keep !== 4'b1111) begin
      errs++; $display("FAIL mid_fresh got %b/%h/%b want 1/a4a3a2a1/1111", p_out.valid, p_out.data, p_out.keep);
    end
    tick();
    cmps++; if (p_out.valid !== 1'b0) begin errs++; $display("FAIL mid_single got %b want 0", p_out.valid); end
  endtask

  initial begin
    p_in.valid = 1'b0; p_in.data = '0; p_in.keep = '0; p_in.last = 1'b0;
    m_in.valid = 1'b0; m_in.data = '0; m_in.keep = '0; m_in.last = 1'b0;
    u_in.valid = 1'b0; u_in.data = '0; u_in.keep = '0; u_in.last = 1'b0;
    s_in.valid = 1'b0; s_in.data = '0; s_in.keep = '0; s_in.last = 1'b0;
    p_out.ready = 1'b1;
    m_out.ready = 1'b1;
    u_out.ready = 1'b1;
    s_out.ready = 1'b1;
    test_reset();
    test_pack_full();
    test_pack_last();
    test_pack_drain();
    test_unpack();
    test_pass_bp();
    test_xz();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
